// File: rtl/load_unit.sv
// RV32I load unit: one outstanding load, word-aligned memory read, lane
// extraction with sign/zero extension, and a bounded wait for read data.
module load_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, SEND_AR, WAIT_R, RESP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        req_ready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_data_q;
    logic [31:0] araddr_q;
    logic [4:0]  rsp_rd_q;

    logic        req_legal;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data_d;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_legal = 1'b1;
            3'b001, 3'b101: req_legal = ~req_addr[0];
            3'b010:         req_legal = (req_addr[1:0] == 2'b00);
            default:        req_legal = 1'b0;
        endcase
    end

    // Lane select uses the latched low address bits, not the live request.
    always_comb begin
        byte_lane   = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        half_lane   = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        load_data_d = mem_rdata;
        case (funct3_q)
            3'b000:  load_data_d = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data_d = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data_d = {24'h0, byte_lane};
            3'b101:  load_data_d = {16'h0, half_lane};
            default: load_data_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            araddr_q    <= '0;
            rsp_rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_q   <= req_addr[1:0];
                        funct3_q    <= req_funct3;
                        rsp_rd_q    <= req_rd;
                        araddr_q    <= {req_addr[31:2], 2'b00};
                        rsp_data_q  <= '0;
                        req_ready_q <= 1'b0;
                        if (req_legal) begin
                            rsp_err_q <= 1'b0;
                            arvalid_q <= 1'b1;
                            state_q   <= SEND_AR;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                SEND_AR: begin
                    if (mem_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        rsp_data_q  <= load_data_d;
                        rsp_err_q   <= (mem_rresp != 2'b00);
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign mem_arvalid = arvalid_q;
    assign mem_araddr  = araddr_q;
    assign mem_rready  = rready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: each scenario task drives a load and compares
// the observed handshake, latency and response against hand-computed values.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_rd(req_rd),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rready(mem_rready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one load through a zero-wait (or ar_delay-delayed) memory and
    // reports what was observed; the calling scenario does the comparisons.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic [1:0] rresp,
                            input int ar_delay, input int stall,
                            output bit ar_seen, output logic [31:0] araddr_seen,
                            output bit ar_stable, output int lat,
                            output logic [37:0] rsp_seen, output bit hold_ok,
                            output bit back_idle);
        int cyc;
        req_valid = 1'b1; req_addr = addr; req_funct3 = f3; req_rd = rd;
        step();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_funct3 = 3'b111; req_rd = ~rd;
        cyc = 1;
        ar_seen = mem_arvalid;
        araddr_seen = mem_araddr;
        ar_stable = 1'b1;
        lat = -1;
        if (ar_seen) begin
            for (int i = 0; i < ar_delay; i++) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
                step(); cyc++;
                if (mem_arvalid !== 1'b1 || mem_araddr !== araddr_seen) ar_stable = 1'b0;
            end
            mem_rvalid = 1'b0; mem_arready = 1'b1;
            step(); cyc++;
            mem_arready = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = rresp;
            step(); cyc++;
            mem_rvalid = 1'b0; mem_rresp = 2'b00; mem_rdata = 32'h0;
        end
        if (rsp_valid === 1'b1) lat = cyc;
        rsp_seen = {rsp_err, rsp_data, rsp_rd};
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_funct3 = 3'b000;
            step();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_err, rsp_data, rsp_rd} !== rsp_seen)
                hold_ok = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        back_idle = (req_ready === 1'b1 && rsp_valid === 1'b0 && mem_arvalid === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({req_ready, mem_arvalid, mem_rready, rsp_valid, rsp_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, mem_arvalid, mem_rready, rsp_valid, rsp_err});
        end
        checks++;
        if ({rsp_data, rsp_rd, mem_araddr} !== 69'h0) begin
            errors++;
            $display("FAIL reset_data: data=%h rd=%h araddr=%h want 0", rsp_data, rsp_rd, mem_araddr);
        end
        rst = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_lb();
        bit ar_seen, ar_stable, hold_ok, back_idle;
        logic [31:0] araddr; int lat; logic [37:0] rsp;
        run_load(3'b000, 32'h8000_0003, 5'd7, 32'h80FF_1234, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (araddr !== 32'h8000_0000 || ar_seen !== 1'b1) begin
            errors++; $display("FAIL lb_araddr: got %h (ar=%b) want 80000000", araddr, ar_seen);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL lb_latency: got %0d want 3", lat);
        end
        checks++;
        if (rsp !== {1'b0, 32'hFFFF_FF80, 5'd7}) begin
            errors++; $display("FAIL lb_rsp: got %h want %h", rsp, {1'b0, 32'hFFFF_FF80, 5'd7});
        end
        checks++;
        if (back_idle !== 1'b1) begin
            errors++; $display("FAIL lb_idle: got %b want 1", back_idle);
        end
        $display("lb: addr=80000003 data=%h err=%b lat=%0d", rsp[36:5], rsp[37], lat);
    endtask

    task automatic test_half_byte();
        bit ar_seen, ar_stable, hold_ok, back_idle;
        logic [31:0] araddr; int lat; logic [37:0] rsp;
        run_load(3'b101, 32'h8000_0002, 5'd3, 32'hBEEF_1234, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (rsp !== {1'b0, 32'h0000_BEEF, 5'd3}) begin
            errors++; $display("FAIL lhu_rsp: got %h want %h", rsp, {1'b0, 32'h0000_BEEF, 5'd3});
        end
        $display("lhu: data=%h", rsp[36:5]);
        run_load(3'b001, 32'h8000_0002, 5'd4, 32'hBEEF_1234, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (rsp !== {1'b0, 32'hFFFF_BEEF, 5'd4}) begin
            errors++; $display("FAIL lh_rsp: got %h want %h", rsp, {1'b0, 32'hFFFF_BEEF, 5'd4});
        end
        $display("lh: data=%h", rsp[36:5]);
        run_load(3'b100, 32'h8000_0001, 5'd5, 32'h80FF_1234, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (rsp !== {1'b0, 32'h0000_0012, 5'd5}) begin
            errors++; $display("FAIL lbu_rsp: got %h want %h", rsp, {1'b0, 32'h0000_0012, 5'd5});
        end
        $display("lbu: data=%h", rsp[36:5]);
        run_load(3'b001, 32'h0000_0000, 5'd6, 32'h5555_8001, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (rsp !== {1'b0, 32'hFFFF_8001, 5'd6}) begin
            errors++; $display("FAIL lh_low_rsp: got %h want %h", rsp, {1'b0, 32'hFFFF_8001, 5'd6});
        end
        $display("lh low: data=%h", rsp[36:5]);
        run_load(3'b000, 32'h0000_0000, 5'd8, 32'h8080_807F, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (rsp !== {1'b0, 32'h0000_007F, 5'd8}) begin
            errors++; $display("FAIL lb_pos_rsp: got %h want %h", rsp, {1'b0, 32'h0000_007F, 5'd8});
        end
        $display("lb pos: data=%h", rsp[36:5]);
    endtask

    task automatic test_illegal();
        bit ar_seen, ar_stable, hold_ok, back_idle;
        logic [31:0] araddr; int lat; logic [37:0] rsp;
        run_load(3'b010, 32'h8000_0006, 5'd9, 32'h0, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (ar_seen !== 1'b0 || lat !== 1) begin
            errors++; $display("FAIL lw_misaligned_ar: ar=%b lat=%0d want ar=0 lat=1", ar_seen, lat);
        end
        checks++;
        if (rsp !== {1'b1, 32'h0, 5'd9}) begin
            errors++; $display("FAIL lw_misaligned_rsp: got %h want %h", rsp, {1'b1, 32'h0, 5'd9});
        end
        $display("lw misaligned: ar=%b err=%b data=%h", ar_seen, rsp[37], rsp[36:5]);
        run_load(3'b011, 32'h8000_0000, 5'd10, 32'h0, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (ar_seen !== 1'b0 || rsp !== {1'b1, 32'h0, 5'd10}) begin
            errors++; $display("FAIL funct3_011: ar=%b rsp=%h want ar=0 rsp=%h", ar_seen, rsp, {1'b1, 32'h0, 5'd10});
        end
        $display("funct3 011: ar=%b err=%b", ar_seen, rsp[37]);
        run_load(3'b101, 32'h8000_0003, 5'd11, 32'h0, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (ar_seen !== 1'b0 || rsp[37] !== 1'b1) begin
            errors++; $display("FAIL lhu_odd: ar=%b err=%b want 0/1", ar_seen, rsp[37]);
        end
        $display("lhu odd: ar=%b err=%b", ar_seen, rsp[37]);
    endtask

    task automatic test_bus_error();
        bit ar_seen, ar_stable, hold_ok, back_idle;
        logic [31:0] araddr; int lat; logic [37:0] rsp;
        run_load(3'b010, 32'h8000_0010, 5'd12, 32'hDEAD_BEEF, 2'b10, 3, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (ar_stable !== 1'b1 || araddr !== 32'h8000_0010) begin
            errors++; $display("FAIL berr_ar_stable: stable=%b addr=%h want 1/80000010", ar_stable, araddr);
        end
        checks++;
        if (lat !== 6) begin
            errors++; $display("FAIL berr_latency: got %0d want 6", lat);
        end
        checks++;
        if (rsp !== {1'b1, 32'hDEAD_BEEF, 5'd12}) begin
            errors++; $display("FAIL berr_rsp: got %h want %h", rsp, {1'b1, 32'hDEAD_BEEF, 5'd12});
        end
        $display("bus error: err=%b data=%h lat=%0d", rsp[37], rsp[36:5], lat);
    endtask

    task automatic test_timeout();
        bit ar_seen, ar_stable, hold_ok, back_idle;
        logic [31:0] araddr; int lat; logic [37:0] rsp;
        bit wait_ok = 1'b1;
        req_valid = 1'b1; req_addr = 32'h8000_0020; req_funct3 = 3'b010; req_rd = 5'd13;
        step();
        req_valid = 1'b0;
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || mem_rready !== 1'b1) wait_ok = 1'b0;
            step();
        end
        checks++;
        if (wait_ok !== 1'b1) begin
            errors++; $display("FAIL timeout_wait: WAIT_R not held for 4 cycles");
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, mem_rready} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL timeout_rsp: valid=%b err=%b data=%h rready=%b want 1/1/0/0",
                               rsp_valid, rsp_err, rsp_data, mem_rready);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL timeout_late_rvalid: ready=%b valid=%b err=%b data=%h want 1/0/1/0",
                               req_ready, rsp_valid, rsp_err, rsp_data);
        end
        $display("timeout: err=1 late rvalid ignored");
        run_load(3'b010, 32'h8000_0004, 5'd14, 32'h1234_5678, 2'b00, 0, 0,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (rsp !== {1'b0, 32'h1234_5678, 5'd14} || lat !== 3) begin
            errors++; $display("FAIL after_timeout: rsp=%h lat=%0d want %h lat=3", rsp, lat, {1'b0, 32'h1234_5678, 5'd14});
        end
        $display("after timeout: data=%h lat=%0d", rsp[36:5], lat);
    endtask

    task automatic test_back_to_back();
        bit ar_seen, ar_stable, hold_ok, back_idle;
        logic [31:0] araddr; int lat; logic [37:0] rsp;
        run_load(3'b100, 32'h8000_0002, 5'd15, 32'h00A5_0000, 2'b00, 0, 5,
                 ar_seen, araddr, ar_stable, lat, rsp, hold_ok, back_idle);
        checks++;
        if (hold_ok !== 1'b1) begin
            errors++; $display("FAIL stall_hold: rsp outputs or req_ready changed during stall");
        end
        checks++;
        if (rsp !== {1'b0, 32'h0000_00A5, 5'd15} || back_idle !== 1'b1) begin
            errors++; $display("FAIL stall_rsp: rsp=%h idle=%b want %h idle=1", rsp, back_idle, {1'b0, 32'h0000_00A5, 5'd15});
        end
        $display("stall: data=%h held=%b", rsp[36:5], hold_ok);
    endtask

    task automatic test_reset_midflight();
        req_valid = 1'b1; req_addr = 32'h8000_0030; req_funct3 = 3'b010; req_rd = 5'd16;
        step();
        req_valid = 1'b0;
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, mem_rready, mem_arvalid} !== 4'b1000 || rsp_rd !== 5'd0) begin
            errors++; $display("FAIL reset_wait_r: ready/valid/rready/arvalid=%b rd=%h want 1000 rd=0",
                               {req_ready, rsp_valid, mem_rready, mem_arvalid}, rsp_rd);
        end
        step(); step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_rsp: rsp_valid=%b want 0", rsp_valid);
        end
        $display("reset in WAIT_R: back to IDLE");
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0; rsp_ready = 1'b0;
        test_reset();
        test_lb();
        test_half_byte();
        test_illegal();
        test_bus_error();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
